// File: rtl/rv32e_fetch_exec_core_if.sv
// Bus bundle between the RV32E core and its register file, instruction memory and data memory.
// master = core side, slave = memories/register file/harness side.
interface rv32e_fetch_exec_core_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [3:0]  rf_raddr1;
    logic [3:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [3:0]  rf_waddr;
    logic        rf_wen;
    logic [31:0] rf_wdata;
    logic [31:0] dmem_addr;
    logic        dmem_ren;
    logic [31:0] dmem_rdata;
    logic        dmem_wen;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic        ebreak;
    logic        illegal;

    modport master (
        output imem_addr, inst, pc, pc_next, rf_raddr1, rf_raddr2, rf_waddr, rf_wen, rf_wdata,
               dmem_addr, dmem_ren, dmem_wen, dmem_wmask, dmem_wdata, ebreak, illegal,
        input  imem_rdata, rf_rdata1, rf_rdata2, dmem_rdata
    );

    modport slave (
        input  imem_addr, inst, pc, pc_next, rf_raddr1, rf_raddr2, rf_waddr, rf_wen, rf_wdata,
               dmem_addr, dmem_ren, dmem_wen, dmem_wmask, dmem_wdata, ebreak, illegal,
        output imem_rdata, rf_rdata1, rf_rdata2, dmem_rdata
    );
endinterface

// File: rtl/rv32e_fetch_exec_core.sv
// Single-cycle RV32E core: PC register plus fully combinational fetch/decode/execute/writeback.
// Register file and memories are external; only the PC is state here.
module rv32e_fetch_exec_core #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input logic                    clk,
    input logic                    rst,
    rv32e_fetch_exec_core_if.master bus
);
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_e;
    typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} asel_e;
    typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} bsel_e;

    function automatic alu_e alu_dec(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_dec = alt ? ALU_SUB : ALU_ADD;
            3'd1:    alu_dec = ALU_SLL;
            3'd2:    alu_dec = ALU_SLT;
            3'd3:    alu_dec = ALU_SLTU;
            3'd4:    alu_dec = ALU_XOR;
            3'd5:    alu_dec = alt ? ALU_SRA : ALU_SRL;
            3'd6:    alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    endfunction

    logic [31:0] r_pc;
    logic [31:0] w_inst, w_rs1, w_rs2, w_pc_next;
    logic [6:0]  w_opc, w_f7;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm;
    asel_e       w_asel;
    bsel_e       w_bsel;
    alu_e        w_aluop;
    logic        w_wen, w_ren, w_sto, w_ill, w_jal, w_jalr, w_br, w_halt, w_taken;
    logic [31:0] w_a, w_b, w_alu;
    logic [31:0] w_lbyte, w_lhalf, w_load;

    assign w_inst  = bus.imem_rdata;
    assign w_rs1   = bus.rf_rdata1;
    assign w_rs2   = bus.rf_rdata2;
    assign w_opc   = w_inst[6:0];
    assign w_f3    = w_inst[14:12];
    assign w_f7    = w_inst[31:25];
    assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'b0};
    assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_pc <= RESET_PC;
        else      r_pc <= w_pc_next;
    end

    always_comb begin
        w_asel  = A_RS1;
        w_bsel  = B_IMM;
        w_aluop = ALU_ADD;
        w_imm   = w_imm_i;
        w_wen   = 1'b0;
        w_ren   = 1'b0;
        w_sto   = 1'b0;
        w_ill   = 1'b0;
        w_jal   = 1'b0;
        w_jalr  = 1'b0;
        w_br    = 1'b0;
        w_halt  = 1'b0;
        case (w_opc)
            7'h37: begin w_asel = A_ZERO; w_imm = w_imm_u; w_wen = 1'b1; end
            7'h17: begin w_asel = A_PC;   w_imm = w_imm_u; w_wen = 1'b1; end
            7'h6F: begin
                w_asel = A_PC; w_bsel = B_FOUR; w_imm = w_imm_j; w_wen = 1'b1; w_jal = 1'b1;
            end
            7'h67: begin
                w_asel = A_PC; w_bsel = B_FOUR;
                if (w_f3 == 3'd0) begin w_wen = 1'b1; w_jalr = 1'b1; end
                else w_ill = 1'b1;
            end
            7'h63: begin
                w_imm = w_imm_b;
                if (w_f3 == 3'd2 || w_f3 == 3'd3) w_ill = 1'b1;
                else                              w_br  = 1'b1;
            end
            7'h03: begin
                if (w_f3 == 3'd3 || w_f3 == 3'd6 || w_f3 == 3'd7) w_ill = 1'b1;
                else begin w_ren = 1'b1; w_wen = 1'b1; end
            end
            7'h23: begin
                w_imm = w_imm_s;
                if (w_f3 < 3'd3) w_sto = 1'b1;
                else             w_ill = 1'b1;
            end
            7'h13: begin
                // inst[30] only selects SRAI; ADDI with that bit set is still an add
                w_aluop = alu_dec(w_f3, (w_f3 == 3'd5) && w_inst[30]);
                if ((w_f3 == 3'd1 && w_f7 != 7'h00) ||
                    (w_f3 == 3'd5 && w_f7 != 7'h00 && w_f7 != 7'h20)) w_ill = 1'b1;
                else w_wen = 1'b1;
            end
            7'h33: begin
                w_bsel  = B_RS2;
                w_aluop = alu_dec(w_f3, w_inst[30]);
                if (w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5))) w_wen = 1'b1;
                else w_ill = 1'b1;
            end
            7'h73: begin
                if (w_inst == EBREAK_INST) w_halt = 1'b1;
                else                       w_ill  = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
    end

    always_comb begin
        case (w_asel)
            A_PC:    w_a = r_pc;
            A_ZERO:  w_a = 32'd0;
            default: w_a = w_rs1;
        endcase
        case (w_bsel)
            B_RS2:   w_b = w_rs2;
            B_FOUR:  w_b = 32'd4;
            default: w_b = w_imm;
        endcase
    end

    always_comb begin
        case (w_aluop)
            ALU_SUB:  w_alu = w_a - w_b;
            ALU_SLL:  w_alu = w_a << w_b[4:0];
            ALU_SLT:  w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
            ALU_SLTU: w_alu = {31'd0, w_a < w_b};
            ALU_XOR:  w_alu = w_a ^ w_b;
            ALU_SRL:  w_alu = w_a >> w_b[4:0];
            ALU_SRA:  w_alu = $unsigned($signed(w_a) >>> w_b[4:0]);
            ALU_OR:   w_alu = w_a | w_b;
            ALU_AND:  w_alu = w_a & w_b;
            default:  w_alu = w_a + w_b;
        endcase
    end

    always_comb begin
        case (w_f3)
            3'd0, 3'd5: w_taken = (w_rs1 == w_rs2) ^ w_f3[0];
            3'd1:       w_taken = w_rs1 != w_rs2;
            3'd4:       w_taken = $signed(w_rs1) < $signed(w_rs2);
            3'd6:       w_taken = w_rs1 < w_rs2;
            default:    w_taken = w_rs1 >= w_rs2;
        endcase
        if (w_f3 == 3'd5) w_taken = !($signed(w_rs1) < $signed(w_rs2));
    end

    always_comb begin
        if (!rst)                     w_pc_next = RESET_PC;
        else if (w_halt)              w_pc_next = r_pc;
        else if (w_jal || (w_br && w_taken)) w_pc_next = r_pc + w_imm;
        else if (w_jalr)              w_pc_next = (w_rs1 + w_imm_i) & 32'hFFFF_FFFE;
        else                          w_pc_next = r_pc + 32'd4;
    end

    // Memory address is the ALU sum rs1+imm for both loads and stores
    assign w_lbyte = bus.dmem_rdata >> {w_alu[1:0], 3'b000};
    assign w_lhalf = w_alu[1] ? {16'd0, bus.dmem_rdata[31:16]} : {16'd0, bus.dmem_rdata[15:0]};

    always_comb begin
        case (w_f3)
            3'd0:    w_load = {{24{w_lbyte[7]}}, w_lbyte[7:0]};
            3'd1:    w_load = {{16{w_lhalf[15]}}, w_lhalf[15:0]};
            3'd4:    w_load = {24'd0, w_lbyte[7:0]};
            3'd5:    w_load = w_lhalf;
            default: w_load = bus.dmem_rdata;
        endcase
    end

    always_comb begin
        case (w_f3[1:0])
            2'd0:    begin bus.dmem_wmask = 4'b0001 << w_alu[1:0];       bus.dmem_wdata = {4{w_rs2[7:0]}}; end
            2'd1:    begin bus.dmem_wmask = 4'b0011 << {w_alu[1], 1'b0}; bus.dmem_wdata = {2{w_rs2[15:0]}}; end
            default: begin bus.dmem_wmask = 4'b1111;                     bus.dmem_wdata = w_rs2; end
        endcase
    end

    assign bus.imem_addr = r_pc;
    assign bus.pc        = r_pc;
    assign bus.pc_next   = w_pc_next;
    assign bus.inst      = w_inst;
    assign bus.rf_raddr1 = w_inst[18:15];
    assign bus.rf_raddr2 = w_inst[23:20];
    assign bus.rf_waddr  = w_inst[10:7];
    // Reset kills side effects combinationally, even mid-cycle
    assign bus.rf_wen    = rst & w_wen;
    assign bus.rf_wdata  = w_ren ? w_load : w_alu;
    assign bus.dmem_addr = w_alu;
    assign bus.dmem_ren  = rst & w_ren;
    assign bus.dmem_wen  = rst & w_sto;
    assign bus.ebreak    = w_halt;
    assign bus.illegal   = w_ill;
endmodule

// File: tb/tb_rv32e_fetch_exec_core.sv
// Bench for rv32e_fetch_exec_core: directed vector table, halt/reset sequences, then random
// instructions checked against an instruction-level reference model.
module tb_rv32e_fetch_exec_core;
    localparam logic [31:0] RPC = 32'h8000_0000;
    localparam logic [31:0] EBK = 32'h0010_0073;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv32e_fetch_exec_core_if bus();
    rv32e_fetch_exec_core #(.RESET_PC(RPC)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] inst, r1, r2, drd;
        logic wen; logic wrel; logic [31:0] wd;
        logic nrel; logic [31:0] npc;
        logic dwen; logic [3:0] mask; logic [31:0] sd;
        logic ill;
    } vec_t;

    typedef struct {
        logic wen; logic [31:0] wd; logic [31:0] npc;
        logic dwen; logic dren; logic [3:0] mask; logic [31:0] sd; logic [31:0] addr;
        logic ill; logic ebk;
    } exp_t;

    int nvec = 0;
    int nerr = 0;
    logic [31:0] pc_model;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h (pc %h inst %h)", name, act, exp, pc_model, bus.imem_rdata);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Instruction-level reference: what each mnemonic does, in plain arithmetic
    function automatic exp_t model(input logic [31:0] in, pc, a, b, drd);
        exp_t e;
        logic [31:0] iI, iS, iB, iU, iJ, ea, op, bt, hf;
        logic [2:0] f3;
        logic [6:0] f7;
        logic t, isreg, ok;
        iI = {{20{in[31]}}, in[31:20]};
        iS = {{20{in[31]}}, in[31:25], in[11:7]};
        iB = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
        iU = {in[31:12], 12'b0};
        iJ = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
        f3 = in[14:12];
        f7 = in[31:25];
        e = '{default: 0};
        e.npc = pc + 4;
        e.ebk = (in == EBK);
        t = 1'b0;
        case (in[6:0])
            7'h37: begin e.wen = 1; e.wd = iU; end
            7'h17: begin e.wen = 1; e.wd = pc + iU; end
            7'h6F: begin e.wen = 1; e.wd = pc + 4; e.npc = pc + iJ; end
            7'h67: if (f3 != 0) e.ill = 1;
                   else begin e.wen = 1; e.wd = pc + 4; e.npc = (a + iI) & 32'hFFFF_FFFE; end
            7'h63: begin
                case (f3)
                    0: t = (a == b);
                    1: t = (a != b);
                    4: t = ($signed(a) < $signed(b));
                    5: t = ($signed(a) >= $signed(b));
                    6: t = (a < b);
                    7: t = (a >= b);
                    default: e.ill = 1;
                endcase
                if (t) e.npc = pc + iB;
            end
            7'h03: begin
                ea = a + iI; e.addr = ea;
                bt = (drd >> (8 * ea[1:0])) & 32'hFF;
                hf = (drd >> (16 * ea[1])) & 32'hFFFF;
                case (f3)
                    0: e.wd = bt[7] ? (bt | 32'hFFFF_FF00) : bt;
                    1: e.wd = hf[15] ? (hf | 32'hFFFF_0000) : hf;
                    2: e.wd = drd;
                    4: e.wd = bt;
                    5: e.wd = hf;
                    default: e.ill = 1;
                endcase
                e.wen = 1; e.dren = 1;
            end
            7'h23: begin
                ea = a + iS; e.addr = ea; e.dwen = 1;
                case (f3)
                    0: begin e.mask = 4'(1 << ea[1:0]); e.sd = {4{b[7:0]}}; end
                    1: begin e.mask = 4'(3 << (2 * ea[1])); e.sd = {2{b[15:0]}}; end
                    2: begin e.mask = 4'hF; e.sd = b; end
                    default: e.ill = 1;
                endcase
            end
            7'h13, 7'h33: begin
                isreg = in[5];
                op = isreg ? b : iI;
                if (isreg) ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                else ok = !((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20));
                case (f3)
                    0: e.wd = (isreg && f7 == 7'h20) ? a - op : a + op;
                    1: e.wd = a << op[4:0];
                    2: e.wd = ($signed(a) < $signed(op)) ? 1 : 0;
                    3: e.wd = (a < op) ? 1 : 0;
                    4: e.wd = a ^ op;
                    5: e.wd = f7[5] ? $unsigned($signed(a) >>> op[4:0]) : a >> op[4:0];
                    6: e.wd = a | op;
                    default: e.wd = a & op;
                endcase
                e.wen = 1;
                if (!ok) e.ill = 1;
            end
            7'h73: if (e.ebk) e.npc = pc; else e.ill = 1;
            default: e.ill = 1;
        endcase
        if (e.ill) begin e.wen = 0; e.dwen = 0; e.dren = 0; e.npc = pc + 4; end
        return e;
    endfunction

    task automatic drive(input logic [31:0] in, r1, r2, drd);
        bus.imem_rdata = in;
        bus.rf_rdata1  = r1;
        bus.rf_rdata2  = r2;
        bus.dmem_rdata = drd;
    endtask

    task automatic step(input logic [31:0] npc);
        @(posedge clk);
        #1;
        pc_model = npc;
    endtask

    vec_t tv[14];
    logic [6:0] ops[10];

    initial begin
        exp_t e;
        logic [31:0] in, ewd, enpc;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        //        inst          r1            r2            drd          wen wrel wd            nrel npc           dwen mask     sd            ill
        tv[0]  = '{32'hFFF00093, 32'h0,        32'h0,        32'h0,        1, 0, 32'hFFFF_FFFF, 1, 32'd4,        0, 4'b0000, 32'h0,        0};
        tv[1]  = '{32'h0020C463, 32'hFFFF_FFFF, 32'h1,       32'h0,        0, 0, 32'h0,         1, 32'd8,        0, 4'b0000, 32'h0,        0};
        tv[2]  = '{32'h0020E463, 32'hFFFF_FFFF, 32'h1,       32'h0,        0, 0, 32'h0,         1, 32'd4,        0, 4'b0000, 32'h0,        0};
        tv[3]  = '{32'h004100E7, 32'h8000_0011, 32'h0,       32'h0,        1, 1, 32'd4,         0, 32'h8000_0014, 0, 4'b0000, 32'h0,       0};
        tv[4]  = '{32'h002080A3, 32'h8000_0000, 32'hAB,      32'h0,        0, 0, 32'h0,         1, 32'd4,        1, 4'b0010, 32'h0000_AB00, 0};
        tv[5]  = '{32'h00108183, 32'h8000_0000, 32'h0,       32'h0000_AB00, 1, 0, 32'hFFFF_FFAB, 1, 32'd4,       0, 4'b0000, 32'h0,        0};
        tv[6]  = '{32'h402081B3, 32'd5,        32'd7,        32'h0,        1, 0, 32'hFFFF_FFFE, 1, 32'd4,        0, 4'b0000, 32'h0,        0};
        tv[7]  = '{32'h4040D193, 32'h8000_0000, 32'h0,       32'h0,        1, 0, 32'hF800_0000, 1, 32'd4,        0, 4'b0000, 32'h0,        0};
        tv[8]  = '{32'h123452B7, 32'h0,        32'h0,        32'h0,        1, 0, 32'h1234_5000, 1, 32'd4,        0, 4'b0000, 32'h0,        0};
        tv[9]  = '{32'h00209123, 32'h8000_0001, 32'h1234_BEEF, 32'h0,      0, 0, 32'h0,         1, 32'd4,        1, 4'b1100, 32'hBEEF_0000, 0};
        tv[10] = '{32'h0000_0000, 32'h0,       32'h0,        32'h0,        0, 0, 32'h0,         1, 32'd4,        0, 4'b0000, 32'h0,        1};
        tv[11] = '{32'h0000_0073, 32'h0,       32'h0,        32'h0,        0, 0, 32'h0,         1, 32'd4,        0, 4'b0000, 32'h0,        1};
        tv[12] = '{32'h0000D183, 32'h8000_0003, 32'h0,       32'hF00D_1234, 1, 0, 32'h0000_F00D, 1, 32'd4,       0, 4'b0000, 32'h0,        0};
        tv[13] = '{32'h010000EF, 32'h0,        32'h0,        32'h0,        1, 1, 32'd4,         1, 32'd16,       0, 4'b0000, 32'h0,        0};

        // Reset state, with a writing instruction on the bus to prove gating
        pc_model = RPC;
        rst = 1'b0;
        drive(32'hFFF00093, 32'h0, 32'h0, 32'h0);
        #7;
        chk("rst_pc", bus.pc, RPC);
        chk("rst_pc_next", bus.pc_next, RPC);
        chk("rst_rf_wen", bus.rf_wen, 0);
        chk("rst_dmem_wen", bus.dmem_wen, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_imem_addr", bus.imem_addr, RPC);

        for (int i = 0; i < 14; i++) begin
            drive(tv[i].inst, tv[i].r1, tv[i].r2, tv[i].drd);
            ewd  = tv[i].wrel ? pc_model + tv[i].wd : tv[i].wd;
            enpc = tv[i].nrel ? pc_model + tv[i].npc : tv[i].npc;
            #2;
            chk($sformatf("tv%0d_imem_addr", i), bus.imem_addr, pc_model);
            chk($sformatf("tv%0d_rf_wen", i), bus.rf_wen, tv[i].wen);
            if (tv[i].wen) chk($sformatf("tv%0d_rf_wdata", i), bus.rf_wdata, ewd);
            chk($sformatf("tv%0d_pc_next", i), bus.pc_next, enpc);
            chk($sformatf("tv%0d_dmem_wen", i), bus.dmem_wen, tv[i].dwen);
            if (tv[i].dwen) begin
                chk($sformatf("tv%0d_wmask", i), bus.dmem_wmask, tv[i].mask);
                chk($sformatf("tv%0d_wdata", i), bus.dmem_wdata & lanes(tv[i].mask), tv[i].sd);
            end
            chk($sformatf("tv%0d_illegal", i), bus.illegal, tv[i].ill);
            step(enpc);
        end

        // EBREAK: no writes, PC frozen over several clocks
        drive(EBK, 32'h1, 32'h2, 32'h0);
        #2;
        chk("ebk_flag", bus.ebreak, 1);
        chk("ebk_rf_wen", bus.rf_wen, 0);
        chk("ebk_pc_next", bus.pc_next, pc_model);
        repeat (3) @(posedge clk);
        #1;
        chk("ebk_pc_hold", bus.pc, pc_model);
        chk("ebk_still", bus.ebreak, 1);

        // Reset dropped while a store is on the bus
        drive(32'h0020A023, 32'h8000_0100, 32'h55, 32'h0);
        #1;
        chk("sw_pre_wen", bus.dmem_wen, 1);
        rst = 1'b0;
        #1;
        chk("midrst_dmem_wen", bus.dmem_wen, 0);
        chk("midrst_pc", bus.pc, RPC);
        chk("midrst_pc_next", bus.pc_next, RPC);
        drive(32'h00108183, 32'h0, 32'h0, 32'h0);
        #1;
        chk("midrst_rf_wen", bus.rf_wen, 0);
        chk("midrst_dmem_ren", bus.dmem_ren, 0);
        @(negedge clk);
        rst = 1'b1;
        pc_model = RPC;

        for (int n = 0; n < 400; n++) begin
            int k;
            logic [31:0] r1, r2, drd;
            in = $urandom();
            k = $urandom_range(0, 10);
            if (k < 10) in[6:0] = ops[k];
            if ((in[6:0] == 7'h13 || in[6:0] == 7'h33) && $urandom_range(0, 3) != 0)
                in[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            if (in[6:0] == 7'h67 && $urandom_range(0, 3) != 0) in[14:12] = 3'd0;
            if (in[6:0] == 7'h73 && $urandom_range(0, 3) == 0) in = EBK;
            r1  = $urandom();
            r2  = $urandom_range(0, 3) == 0 ? r1 : $urandom();
            drd = $urandom();
            e = model(in, pc_model, r1, r2, drd);
            drive(in, r1, r2, drd);
            #2;
            chk("r_imem_addr", bus.imem_addr, pc_model);
            chk("r_inst", bus.inst, in);
            chk("r_regaddr", {20'd0, bus.rf_raddr1, bus.rf_raddr2, bus.rf_waddr},
                {20'd0, in[18:15], in[23:20], in[10:7]});
            chk("r_rf_wen", bus.rf_wen, e.wen);
            if (e.wen) chk("r_rf_wdata", bus.rf_wdata, e.wd);
            chk("r_pc_next", bus.pc_next, e.npc);
            chk("r_dmem_wen", bus.dmem_wen, e.dwen);
            chk("r_dmem_ren", bus.dmem_ren, e.dren);
            if (e.dwen) begin
                chk("r_wmask", bus.dmem_wmask, e.mask);
                chk("r_wdata", bus.dmem_wdata & lanes(e.mask), e.sd & lanes(e.mask));
            end
            if (e.dwen || e.dren) chk("r_dmem_addr", bus.dmem_addr, e.addr);
            chk("r_illegal", bus.illegal, e.ill);
            chk("r_ebreak", bus.ebreak, e.ebk);
            step(e.npc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
